sound_mem_arbiter: RTL

Shares the single SDRAM read/write port used by the sound subsystem between the sound GLU (CPU-side RAM accesses) and the DOC (oscillator wavetable fetches). It replaces the plain OR/address mux between the two sound memory ports with a registered, one-transaction-at-a-time arbiter. DOC requests get priority for audio timing, and a starvation guard bounds GLU latency.

---
 rtl/sound_mem_arbiter.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/sound_mem_arbiter.sv
// Sound SDRAM port arbiter: one registered transaction at a time, shared by the GLU and the DOC.
// DOC has priority with a GLU starvation guard; optional statistics under `SOUND_ARB_STATS_EN.

package sound_arb_pkg;
    typedef struct packed {
        logic        rd;
        logic [23:0] addr;
        logic [31:0] data;
        logic [3:0]  byte_en;
    } snd_req_t;
endpackage

// One client port: pending request register plus its ready/read-data outputs.
module sound_arb_port (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    rd_i,
    input  logic                    wr_i,
    input  logic [23:0]             addr_i,
    input  logic [31:0]             data_i,
    input  logic [3:0]              byte_en_i,
    input  logic                    done_i,
    input  logic [31:0]             sdram_q_i,
    output logic                    pend_o,
    output sound_arb_pkg::snd_req_t req_o,
    output logic                    ready_o,
    output logic [31:0]             q_o
);
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pend_o <= 1'b0;
            req_o  <= '0;
            q_o    <= '0;
        end else if (done_i) begin
            pend_o <= 1'b0;
            if (req_o.rd)
                q_o <= sdram_q_i;
        end else if (!pend_o && (rd_i || wr_i)) begin
            // rd wins when both pulse together
            pend_o        <= 1'b1;
            req_o.rd      <= rd_i;
            req_o.addr    <= addr_i;
            req_o.data    <= data_i;
            req_o.byte_en <= byte_en_i;
        end
    end

    assign ready_o = !pend_o;
endmodule

module sound_mem_arbiter #(
    parameter int GLU_STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        glu_rd_i,
    input  logic        glu_wr_i,
    input  logic [23:0] glu_addr_i,
    input  logic [31:0] glu_data_i,
    input  logic [3:0]  glu_byte_en_i,
    output logic        glu_ready_o,
    output logic [31:0] glu_q_o,
    input  logic        doc_rd_i,
    input  logic        doc_wr_i,
    input  logic [23:0] doc_addr_i,
    input  logic [31:0] doc_data_i,
    input  logic [3:0]  doc_byte_en_i,
    output logic        doc_ready_o,
    output logic [31:0] doc_q_o,
    input  logic        sdram_ready_i,
    output logic        sdram_rd_o,
    output logic        sdram_wr_o,
    output logic [23:0] sdram_addr_o,
    output logic [31:0] sdram_data_o,
    output logic [3:0]  sdram_byte_en_o,
    input  logic [31:0] sdram_q_i,
    output logic [15:0] stat_glu_grants_o,
    output logic [15:0] stat_doc_grants_o,
    output logic [7:0]  stat_glu_max_wait_o
);
    import sound_arb_pkg::*;

    localparam int   NUM_CLIENTS = 2;
    localparam logic GLU         = 1'b0;
    localparam logic DOC         = 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT0, S_WAIT1} state_t;

    logic [NUM_CLIENTS-1:0]        cl_rd, cl_wr, cl_pend, cl_done, cl_ready;
    logic [NUM_CLIENTS-1:0][23:0]  cl_addr;
    logic [NUM_CLIENTS-1:0][31:0]  cl_data, cl_q;
    logic [NUM_CLIENTS-1:0][3:0]   cl_be;
    snd_req_t [NUM_CLIENTS-1:0]    cl_req;

    state_t   state, state_nxt;
    logic     win, sel, issue, done, glu_first;
    logic [3:0] starve_cnt;
    snd_req_t cmd_q, cmd_cur;

    assign cl_rd   = {doc_rd_i, glu_rd_i};
    assign cl_wr   = {doc_wr_i, glu_wr_i};
    assign cl_addr = {doc_addr_i, glu_addr_i};
    assign cl_data = {doc_data_i, glu_data_i};
    assign cl_be   = {doc_byte_en_i, glu_byte_en_i};

    for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_client
        sound_arb_port u_port (
            .clk_i     (clk_i),
            .reset_i   (reset_i),
            .rd_i      (cl_rd[g]),
            .wr_i      (cl_wr[g]),
            .addr_i    (cl_addr[g]),
            .data_i    (cl_data[g]),
            .byte_en_i (cl_be[g]),
            .done_i    (cl_done[g]),
            .sdram_q_i (sdram_q_i),
            .pend_o    (cl_pend[g]),
            .req_o     (cl_req[g]),
            .ready_o   (cl_ready[g]),
            .q_o       (cl_q[g])
        );
        assign cl_done[g] = done && (win == 1'(g));
    end

    assign glu_ready_o = cl_ready[GLU];
    assign doc_ready_o = cl_ready[DOC];
    assign glu_q_o     = cl_q[GLU];
    assign doc_q_o     = cl_q[DOC];

    // GLU takes the slot when DOC is absent or has had its quota of back-to-back wins
    assign glu_first = cl_pend[GLU] &&
                       (!cl_pend[DOC] || (starve_cnt >= 4'(GLU_STARVE_LIMIT)));

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        done      = 1'b0;
        sel       = win;
        case (state)
            S_IDLE: begin
                if (sdram_ready_i && (|cl_pend)) begin
                    issue     = 1'b1;
                    sel       = glu_first ? GLU : DOC;
                    state_nxt = S_WAIT0;
                end
            end
            S_WAIT0: state_nxt = S_WAIT1;  // controller needs a cycle to drop ready
            S_WAIT1: begin
                if (sdram_ready_i) begin
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= S_IDLE;
            win        <= GLU;
            starve_cnt <= '0;
            cmd_q      <= '0;
        end else begin
            state <= state_nxt;
            if (issue) begin
                win   <= sel;
                cmd_q <= cl_req[sel];
                if (sel == GLU)
                    starve_cnt <= '0;
                else if (cl_pend[GLU] && (starve_cnt != 4'hF))
                    starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    // Fields come straight from the winner on the issue cycle, then stay held
    assign cmd_cur         = issue ? cl_req[sel] : cmd_q;
    assign sdram_rd_o      = issue &&  cl_req[sel].rd;
    assign sdram_wr_o      = issue && !cl_req[sel].rd;
    assign sdram_addr_o    = cmd_cur.addr;
    assign sdram_data_o    = cmd_cur.data;
    assign sdram_byte_en_o = cmd_cur.byte_en;

`ifdef SOUND_ARB_STATS_EN
    logic [15:0] glu_grants, doc_grants;
    logic [7:0]  glu_wait, glu_max_wait;
    logic        glu_waiting;

    // Pending but not the transaction currently on the bus
    assign glu_waiting = cl_pend[GLU] && !((state != S_IDLE) && (win == GLU));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            glu_grants   <= '0;
            doc_grants   <= '0;
            glu_wait     <= '0;
            glu_max_wait <= '0;
        end else begin
            if (issue && (sel == GLU)) begin
                glu_grants <= glu_grants + 16'd1;
                glu_wait   <= '0;
                if (glu_wait > glu_max_wait)
                    glu_max_wait <= glu_wait;
            end else if (glu_waiting && (glu_wait != 8'hFF)) begin
                glu_wait <= glu_wait + 8'd1;
            end
            if (issue && (sel == DOC))
                doc_grants <= doc_grants + 16'd1;
        end
    end

    assign stat_glu_grants_o   = glu_grants;
    assign stat_doc_grants_o   = doc_grants;
    assign stat_glu_max_wait_o = glu_max_wait;
`else
    assign stat_glu_grants_o   = '0;
    assign stat_doc_grants_o   = '0;
    assign stat_glu_max_wait_o = '0;
`endif

endmodule
